// File: rtl/lc3_execute_stage.sv
// LC-3 Execute stage: operand forwarding, ALU, address adder and the
// registered execute_out bus consumed by MemAccess, Writeback and Fetch.
module lc3_execute_stage #(
    parameter int DATA_W   = 16,
    parameter int REG_ID_W = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable_execute,
    input  logic [5:0]          E_Control,
    input  logic [DATA_W-1:0]   IR,
    input  logic [DATA_W-1:0]   npc,
    input  logic [1:0]          W_Control_in,
    input  logic                Mem_Control_in,
    input  logic [DATA_W-1:0]   VSR1,
    input  logic [DATA_W-1:0]   VSR2,
    input  logic                bypass_alu_1,
    input  logic                bypass_alu_2,
    input  logic                bypass_mem_1,
    input  logic                bypass_mem_2,
    input  logic [DATA_W-1:0]   Mem_Bypass_Val,
    output logic [DATA_W-1:0]   aluout,
    output logic [1:0]          W_Control_out,
    output logic                Mem_Control_out,
    output logic [DATA_W-1:0]   M_Data,
    output logic [REG_ID_W-1:0] dr,
    output logic [REG_ID_W-1:0] sr1,
    output logic [REG_ID_W-1:0] sr2,
    output logic [DATA_W-1:0]   pcout,
    output logic [DATA_W-1:0]   IR_Exec,
    output logic [REG_ID_W-1:0] NZP
);

    function automatic logic [DATA_W-1:0] sext5(input logic [4:0] f);
        return {{(DATA_W-5){f[4]}}, f};
    endfunction

    function automatic logic [DATA_W-1:0] sext6(input logic [5:0] f);
        return {{(DATA_W-6){f[5]}}, f};
    endfunction

    function automatic logic [DATA_W-1:0] sext9(input logic [8:0] f);
        return {{(DATA_W-9){f[8]}}, f};
    endfunction

    function automatic logic [DATA_W-1:0] sext11(input logic [10:0] f);
        return {{(DATA_W-11){f[10]}}, f};
    endfunction

    logic [DATA_W-1:0]   aluout_q, aluout_d;
    logic [DATA_W-1:0]   pcout_q, pcout_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [DATA_W-1:0]   ir_exec_q, ir_exec_d;
    logic [REG_ID_W-1:0] dr_q, dr_d;
    logic [REG_ID_W-1:0] nzp_q, nzp_d;
    logic [1:0]          w_control_q, w_control_d;
    logic                mem_control_q, mem_control_d;

    logic [1:0]        alu_control;
    logic [1:0]        pcselect1;
    logic              pcselect2;
    logic              op2select;
    logic [3:0]        opcode;
    logic              is_alu_op;
    logic              is_store;
    logic              writes_dr;
    logic [DATA_W-1:0] val_1, val_2;
    logic [DATA_W-1:0] alu_b, alu_res;
    logic [DATA_W-1:0] addr1, addr2, addr_sum;

    assign {alu_control, pcselect1, pcselect2, op2select} = E_Control;
    assign opcode = IR[15:12];

    assign is_alu_op = (opcode == 4'b0001) || (opcode == 4'b0101) || (opcode == 4'b1001);
    assign is_store  = (opcode == 4'b0011) || (opcode == 4'b0111) || (opcode == 4'b1011);
    assign writes_dr = is_alu_op || (opcode == 4'b0010) || (opcode == 4'b0110)
                    || (opcode == 4'b1010) || (opcode == 4'b1110);

    // Stores name their data register in the DR field, so sr2 is steered there.
    assign sr1 = IR[8:6];
    assign sr2 = is_store ? IR[11:9] : IR[2:0];

    always_comb begin
        val_1 = bypass_alu_1 ? aluout_q : (bypass_mem_1 ? Mem_Bypass_Val : VSR1);
        val_2 = bypass_alu_2 ? aluout_q : (bypass_mem_2 ? Mem_Bypass_Val : VSR2);
        alu_b = op2select ? val_2 : sext5(IR[4:0]);

        case (alu_control)
            2'b01:   alu_res = val_1 & alu_b;
            2'b10:   alu_res = ~val_1;
            default: alu_res = val_1 + alu_b;
        endcase

        case (pcselect1)
            2'b00:   addr1 = sext11(IR[10:0]);
            2'b01:   addr1 = sext9(IR[8:0]);
            2'b10:   addr1 = sext6(IR[5:0]);
            default: addr1 = '0;
        endcase
        addr2    = pcselect2 ? npc : val_1;
        addr_sum = addr1 + addr2;
    end

    // Stage boundary: everything holds on a stalled edge except NZP, which
    // clears so a branch is only ever presented for one enabled cycle.
    always_comb begin
        aluout_d      = aluout_q;
        pcout_d       = pcout_q;
        m_data_d      = m_data_q;
        ir_exec_d     = ir_exec_q;
        dr_d          = dr_q;
        nzp_d         = '0;
        w_control_d   = w_control_q;
        mem_control_d = mem_control_q;
        if (enable_execute) begin
            aluout_d      = is_alu_op ? alu_res : addr_sum;
            pcout_d       = addr_sum;
            m_data_d      = val_2;
            ir_exec_d     = IR;
            dr_d          = writes_dr ? IR[11:9] : '0;
            w_control_d   = W_Control_in;
            mem_control_d = Mem_Control_in;
            if (opcode == 4'b0000)
                nzp_d = IR[11:9];
            else if (opcode == 4'b1100)
                nzp_d = {REG_ID_W{1'b1}};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aluout_q      <= '0;
            pcout_q       <= '0;
            m_data_q      <= '0;
            ir_exec_q     <= '0;
            dr_q          <= '0;
            nzp_q         <= '0;
            w_control_q   <= '0;
            mem_control_q <= 1'b0;
        end else begin
            aluout_q      <= aluout_d;
            pcout_q       <= pcout_d;
            m_data_q      <= m_data_d;
            ir_exec_q     <= ir_exec_d;
            dr_q          <= dr_d;
            nzp_q         <= nzp_d;
            w_control_q   <= w_control_d;
            mem_control_q <= mem_control_d;
        end
    end

    assign aluout          = aluout_q;
    assign pcout           = pcout_q;
    assign M_Data          = m_data_q;
    assign IR_Exec         = ir_exec_q;
    assign dr              = dr_q;
    assign NZP             = nzp_q;
    assign W_Control_out   = w_control_q;
    assign Mem_Control_out = mem_control_q;

endmodule

// File: tb/tb_lc3_execute_stage.sv
// Self-checking bench for lc3_execute_stage: directed scenarios plus random
// traffic, scored against a queue of expected bus values from a reference model.
module tb_lc3_execute_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_execute;
    logic [5:0]  E_Control;
    logic [15:0] IR, npc, VSR1, VSR2, Mem_Bypass_Val;
    logic [1:0]  W_Control_in;
    logic        Mem_Control_in;
    logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
    logic [15:0] aluout, M_Data, pcout, IR_Exec;
    logic [1:0]  W_Control_out;
    logic        Mem_Control_out;
    logic [2:0]  dr, sr1, sr2, NZP;

    lc3_execute_stage dut (
        .clock(clock), .reset(reset), .enable_execute(enable_execute),
        .E_Control(E_Control), .IR(IR), .npc(npc),
        .W_Control_in(W_Control_in), .Mem_Control_in(Mem_Control_in),
        .VSR1(VSR1), .VSR2(VSR2),
        .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
        .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
        .Mem_Bypass_Val(Mem_Bypass_Val),
        .aluout(aluout), .W_Control_out(W_Control_out),
        .Mem_Control_out(Mem_Control_out), .M_Data(M_Data),
        .dr(dr), .sr1(sr1), .sr2(sr2), .pcout(pcout),
        .IR_Exec(IR_Exec), .NZP(NZP)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] alu;
        logic [15:0] pc;
        logic [15:0] md;
        logic [15:0] ir;
        logic [2:0]  dr;
        logic [2:0]  nzp;
        logic [1:0]  wc;
        logic        mc;
    } exp_t;

    exp_t st;
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    endtask

    function automatic exp_t model(input exp_t prev, input logic en);
        exp_t        r;
        logic [15:0] a, b2, b, alu, a1, a2, pc;
        logic [3:0]  op;
        r  = prev;
        r.nzp = 3'b000;
        if (!en) return r;
        op = IR[15:12];
        a  = bypass_alu_1 ? prev.alu : (bypass_mem_1 ? Mem_Bypass_Val : VSR1);
        b2 = bypass_alu_2 ? prev.alu : (bypass_mem_2 ? Mem_Bypass_Val : VSR2);
        b  = E_Control[0] ? b2 : {{11{IR[4]}}, IR[4:0]};
        if (E_Control[5:4] == 2'b01)      alu = a & b;
        else if (E_Control[5:4] == 2'b10) alu = ~a;
        else                              alu = a + b;
        if (E_Control[3:2] == 2'b00)      a1 = {{5{IR[10]}}, IR[10:0]};
        else if (E_Control[3:2] == 2'b01) a1 = {{7{IR[8]}}, IR[8:0]};
        else if (E_Control[3:2] == 2'b10) a1 = {{10{IR[5]}}, IR[5:0]};
        else                              a1 = 16'h0000;
        a2 = E_Control[1] ? npc : a;
        pc = a1 + a2;
        r.pc  = pc;
        r.alu = (op == 4'd1 || op == 4'd5 || op == 4'd9) ? alu : pc;
        r.md  = b2;
        r.ir  = IR;
        r.wc  = W_Control_in;
        r.mc  = Mem_Control_in;
        r.dr  = (op inside {4'd1, 4'd5, 4'd9, 4'd2, 4'd6, 4'd10, 4'd14}) ? IR[11:9] : 3'b000;
        if (op == 4'd0)       r.nzp = IR[11:9];
        else if (op == 4'd12) r.nzp = 3'b111;
        return r;
    endfunction

    task automatic compare_bus(input string tag, input exp_t e);
        check_val({tag, ".aluout"}, aluout, e.alu);
        check_val({tag, ".pcout"}, pcout, e.pc);
        check_val({tag, ".M_Data"}, M_Data, e.md);
        check_val({tag, ".IR_Exec"}, IR_Exec, e.ir);
        check_val({tag, ".dr"}, {13'd0, dr}, {13'd0, e.dr});
        check_val({tag, ".NZP"}, {13'd0, NZP}, {13'd0, e.nzp});
        check_val({tag, ".W_Control"}, {14'd0, W_Control_out}, {14'd0, e.wc});
        check_val({tag, ".Mem_Control"}, {15'd0, Mem_Control_out}, {15'd0, e.mc});
    endtask

    task automatic step(input string tag, input logic en);
        exp_t e;
        enable_execute = en;
        sb_q.push_back(model(st, en));
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            check_val({tag, ".scoreboard_empty"}, 16'd0, 16'd1);
        end else begin
            e = sb_q.pop_front();
            compare_bus(tag, e);
            st = e;
        end
    endtask

    task automatic clear_bypass();
        bypass_alu_1 = 0; bypass_alu_2 = 0; bypass_mem_1 = 0; bypass_mem_2 = 0;
    endtask

    initial begin
        reset = 1'b0; enable_execute = 0; E_Control = '0; IR = '0; npc = '0;
        VSR1 = '0; VSR2 = '0; Mem_Bypass_Val = '0; W_Control_in = '0;
        Mem_Control_in = 0;
        clear_bypass();
        st = '0;
        #7;
        compare_bus("reset", '0);
        #1 reset = 1'b1;

        // ADD R0,R1,R2
        IR = 16'h1042; VSR1 = 16'd5; VSR2 = 16'd7; E_Control = 6'b000001;
        W_Control_in = 2'b01; Mem_Control_in = 1'b1;
        #1;
        check_val("add.sr1", {13'd0, sr1}, 16'd1);
        check_val("add.sr2", {13'd0, sr2}, 16'd2);
        step("add", 1'b1);
        check_val("add.const_alu", aluout, 16'h000C);

        // NOT via ALU bypass with both selects set: ALU path wins
        bypass_alu_1 = 1; bypass_mem_1 = 1; Mem_Bypass_Val = 16'h00FF;
        VSR1 = 16'h1111; IR = 16'h5060; E_Control = 6'b100000;
        step("bypass", 1'b1);
        check_val("bypass.const_alu", aluout, 16'hFFF3);
        clear_bypass();

        IR = 16'h107F; VSR1 = 16'h0000; E_Control = 6'b000000;
        step("addimm_neg", 1'b1);
        check_val("addimm_neg.const", aluout, 16'hFFFF);
        IR = 16'h1061; VSR1 = 16'hFFFF;
        step("addimm_wrap", 1'b1);
        check_val("addimm_wrap.const", aluout, 16'h0000);

        IR = 16'h0A03; npc = 16'h3001; E_Control = 6'b000110;
        step("branch", 1'b1);
        check_val("branch.const_pc", pcout, 16'h3004);
        check_val("branch.const_nzp", {13'd0, NZP}, 16'd5);
        step("branch_hold", 1'b0);
        check_val("branch_hold.const_nzp", {13'd0, NZP}, 16'd0);
        check_val("branch_hold.const_pc", pcout, 16'h3004);

        IR = 16'h3602; VSR2 = 16'hBEEF; npc = 16'h4000; E_Control = 6'b000110;
        #1;
        check_val("store.sr2", {13'd0, sr2}, 16'd3);
        step("store", 1'b1);
        check_val("store.const_md", M_Data, 16'hBEEF);
        check_val("store.const_alu", aluout, 16'h4002);

        // Asynchronous reset between edges
        IR = 16'h1042; VSR1 = 16'd5; VSR2 = 16'd7; E_Control = 6'b000001;
        step("pre_reset", 1'b1);
        #3 reset = 1'b0;
        #1;
        st = '0;
        compare_bus("async_reset", '0);
        #1 reset = 1'b1;
        step("post_reset_hold", 1'b0);

        for (int i = 0; i < 40; i++) begin
            IR = 16'($urandom); npc = 16'($urandom);
            VSR1 = 16'($urandom); VSR2 = 16'($urandom);
            Mem_Bypass_Val = 16'($urandom); E_Control = 6'($urandom);
            W_Control_in = 2'($urandom); Mem_Control_in = 1'($urandom);
            bypass_alu_1 = 1'($urandom); bypass_alu_2 = 1'($urandom);
            bypass_mem_1 = 1'($urandom); bypass_mem_2 = 1'($urandom);
            #1;
            check_val("rand.sr1", {13'd0, sr1}, {13'd0, IR[8:6]});
            check_val("rand.sr2", {13'd0, sr2},
                      {13'd0, (IR[15:12] inside {4'd3, 4'd7, 4'd11}) ? IR[11:9] : IR[2:0]});
            step("rand", ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lc3_execute_stage.md
Name: lc3_execute_stage

Overview:
- LC-3 pipeline Execute stage: the producer/driver end of the execute_out bus.
- Takes decoded instruction, register operands and bypass selects from Decode/Controller, and computes:
  - ALU result;
  - effective address / branch target;
  - store data;
  - destination/source register IDs;
  - branch condition mask.
- Drives every signal the execute_out agent monitors; MemAccess, Writeback and Fetch consume the outputs.

Parameters:
- DATA_W, 16, datapath width (fixed for LC-3; all arithmetic modulo 2^DATA_W)
- REG_ID_W, 3, register-ID / NZP width

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- enable_execute  input  1  stage advance; registers update only when 1
- E_Control  input  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
- IR  input  16  instruction from Decode
- npc  input  16  PC+1 of this instruction
- W_Control_in  input  2  writeback select, passed through
- Mem_Control_in  input  1  memory-access flag, passed through
- VSR1  input  16  register-file value for sr1
- VSR2  input  16  register-file value for sr2
- bypass_alu_1  input  1  operand 1 from own aluout register
- bypass_alu_2  input  1  operand 2 from own aluout register
- bypass_mem_1  input  1  operand 1 from Mem_Bypass_Val
- bypass_mem_2  input  1  operand 2 from Mem_Bypass_Val
- Mem_Bypass_Val  input  16  forwarded memory read data
- aluout  output  16  registered ALU / address result
- W_Control_out  output  2  registered W_Control_in
- Mem_Control_out  output  1  registered Mem_Control_in
- M_Data  output  16  registered store data (operand 2)
- dr  output  3  registered destination register
- sr1  output  3  combinational IR[8:6]
- sr2  output  3  combinational: IR[11:9] if IR[15:12] is ST/STR/STI (0011/0111/1011), else IR[2:0]
- pcout  output  16  registered address adder result
- IR_Exec  output  16  registered IR
- NZP  output  3  registered branch mask

Behaviour:
- Reset (reset==0, async): all registered outputs = 0, held until reset deasserts. A reset asserted mid-instruction discards in-flight state; the first enabled edge after release loads fresh values.
- Operand select, per operand n (combinational):
  - val_n = bypass_alu_n ? aluout (current register) : bypass_mem_n ? Mem_Bypass_Val : VSRn.
  - ALU bypass has priority when both selects are set.
- ALU operand 2: op2select=1 -> val_2; op2select=0 -> sext(IR[4:0]).
- alu_control:
  - 00 -> A+B.
  - 01 -> A&B.
  - 10 -> ~A.
  - 11 -> reserved; produces A+B.
- Address adder:
  - addr1 per pcselect1: 00 sext(IR[10:0]), 01 sext(IR[8:0]), 10 sext(IR[5:0]), 11 0x0000.
  - addr2 = pcselect2 ? npc : val_1.
  - pcout_next = addr1+addr2, carry dropped (0xFFFF+1 -> 0x0000).
- aluout_next:
  - ALU result when IR[15:12] in {0001 ADD, 0101 AND, 1001 NOT};
  - otherwise pcout_next (LEA and load/store addresses).
- dr_next:
  - IR[11:9] for ADD/AND/NOT/LD/LDR/LDI/LEA;
  - otherwise 0.
- NZP_next:
  - IR[11:9] for BR (0000);
  - 3'b111 for JMP (1100);
  - otherwise 000.
- M_Data_next = val_2.
- Clock edge with enable_execute=1 (1-cycle latency): aluout, pcout, M_Data, dr, NZP, IR_Exec, W_Control_out and Mem_Control_out all load their _next values together.
- Clock edge with enable_execute=0:
  - all registered outputs hold, except NZP, which clears to 000, so a branch is presented for exactly one enabled cycle.
- sr1/sr2 follow IR with zero latency, regardless of enable or reset.
- No internal stall; the downstream stage must sample on the cycle after the enabled edge.

Test Plan:
- ADD register: IR=0x1042, VSR1=5, VSR2=7, E_Control=6'b000001, enable=1 -> next cycle aluout=0x000C, dr=0, IR_Exec=0x1042, sr1=1, sr2=2.
- ADD immediate wrap: IR=0x107F, VSR1=0x0000, op2select=0 -> aluout=0xFFFF; then VSR1=0xFFFF with IR=0x1061 (#1) -> aluout=0x0000.
- Branch: IR=0x0A03, npc=0x3001, pcselect1=01, pcselect2=1 -> pcout=0x3004, NZP=101, dr=0. Following edge with enable=0 -> NZP=000, pcout holds 0x3004.
- Bypass priority: prior aluout=0x000C, bypass_alu_1=1, bypass_mem_1=1, Mem_Bypass_Val=0x00FF, VSR1=0x1111, IR=0x5060 (AND R0,R1,#0 -> op2select=0) with alu_control=10 (NOT) -> aluout=0xFFF3.
- Store: IR=0x3602 (ST R3,#2), VSR2=0xBEEF, npc=0x4000, pcselect1=01, pcselect2=1 -> sr2=3 immediately, M_Data=0xBEEF, pcout=aluout=0x4002, dr=0.
- Reset mid-op: load ADD result 0x000C, assert reset between edges -> all registered outputs 0 immediately (no clock). Release with enable=0 -> outputs stay 0.
